// File: rtl/instruction_fetch_unit.sv
// Clocked fetch stage: owns the PC and instruction memory and feeds decode
// through a registered valid/ready handshake with redirect and fault trap.
module instruction_fetch_unit #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned COUNT_W    = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [31:0]                   out_instr,
  output logic [XLEN-1:0]               out_pc,
  output logic                          inv_addr,
  output logic [COUNT_W-1:0]            fetch_count,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [31:0]                   prog_data
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  typedef enum logic {
    RUN,
    FAULT
  } state_e;

  logic [31:0] mem [IMEM_DEPTH];

  state_e              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic                valid_q, valid_d;
  logic [31:0]         instr_q, instr_d;
  logic [XLEN-1:0]     opc_q, opc_d;
  logic                inv_q, inv_d;
  logic [COUNT_W-1:0]  cnt_q, cnt_d;

  logic          adv;
  logic          xfer;
  logic          pc_ok;
  logic [AW-1:0] idx;

  // Depth is a power of two, so "index < depth" means all upper bits zero.
  assign pc_ok = (pc_q[1:0] == 2'b00) && (pc_q[XLEN-1:AW+2] == '0);
  assign idx   = pc_q[AW+1:2];
  assign adv   = !valid_q || out_ready;
  assign xfer  = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    inv_d   = inv_q;
    cnt_d   = cnt_q;
    if (xfer) begin
      cnt_d = cnt_q + COUNT_W'(1);
    end
    unique case (state_q)
      RUN: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (adv && pc_ok) begin
          instr_d = mem[idx];
          opc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + XLEN'(4);
        end else if (adv) begin
          valid_d = 1'b0;
          inv_d   = 1'b1;
          state_d = FAULT;
        end
      end
      FAULT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          inv_d   = 1'b0;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
    end
  end

  // Contents survive reset; the fetch read above sees the pre-write word.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  assign out_valid   = valid_q;
  assign out_instr   = instr_q;
  assign out_pc      = opc_q;
  assign inv_addr    = inv_q;
  assign fetch_count = cnt_q;

endmodule
